pipelined_rr_arbiter: RTL and testbench
=======================================

Name: pipelined_rr_arbiter

Overview:
- Round-robin arbiter that shares one pipelined server, such as a delay-line or coefficient memory, among n_clients requesters.
- Unlike a one-at-a-time arbiter, it keeps up to max_outstanding requests in flight.
- It records the granted client ID in a tag FIFO.
- Server responses return in order; the FIFO routes each one back to its originating client as a one-cycle ready pulse.

Parameters:
- req_data_width, 16, request payload bits per client
- server_data_width, 16, response payload bits
- n_clients, 8, number of requesters (2..32)
- max_outstanding, 4, tag FIFO depth; power of two, 2..16

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_data_flat  input  n_clients*req_data_width  client i payload at [i*req_data_width +: req_data_width]
- reqs  input  n_clients  client i holds high until it sees readies[i]
- data_out  output  server_data_width  response payload, valid while any readies bit is high
- readies  output  n_clients  one-hot, one-cycle response pulse
- arbiter_req_data  output  req_data_width  payload to server
- arbiter_req  output  1  request valid to server
- server_req_ready  input  1  server accepts a request when high together with arbiter_req
- server_data  input  server_data_width  response payload
- server_valid  input  1  one-cycle response strobe, in issue order
- outstanding  output  $clog2(max_outstanding+1)  tags currently in FIFO
- resp_underflow  output  1  sticky: server_valid seen with FIFO empty

Behaviour:
- Reset, sampled on the clk edge:
  - All outputs go to 0.
  - The round-robin pointer goes to 0.
  - The FIFO empties; pending[] clears.
  - In-flight tags are discarded, not replayed.
- Eligibility: eligible = reqs & ~pending.
- Grant selection:
  - Search starts at the pointer and wraps at n_clients-1 to 0.
  - The first eligible client k is chosen.
  - On grant, the pointer becomes (k+1) mod n_clients.
- Grant condition: an eligible client exists, outstanding < max_outstanding, and the output register is free.
  - The output register is free when arbiter_req is 0, or when arbiter_req && server_req_ready this cycle.
- On grant, registered, visible the next cycle:
  - arbiter_req_data <= payload k and arbiter_req <= 1.
  - Push k into the FIFO and set pending[k].
- Server request handshake:
  - arbiter_req and arbiter_req_data hold stable until a cycle with server_req_ready=1.
  - After the transfer, arbiter_req drops unless a new grant loads in the same edge, which gives back-to-back issue.
  - Latency from a reqs rise (idle arbiter) to arbiter_req is 1 cycle.
- Response path:
  - When server_valid=1 and the FIFO is non-empty: pop head h, data_out <= server_data, readies[h] <= 1 for exactly one cycle.
  - Latency is 1 cycle.
- pending[h] clears at the edge where readies[h] is 1. The client therefore cannot be re-granted on its stale reqs; it must drop reqs at that same edge.
- Simultaneous push and pop in one cycle: both take effect and outstanding is unchanged. A pop in the same cycle also frees a slot, but the full check uses the registered count.
- server_valid with the FIFO empty: the response is discarded, readies stays 0, and resp_underflow <= 1. resp_underflow clears only on reset.
- FIFO uses read/write pointers mod max_outstanding plus the count; it never overflows because grants are blocked when full.
- All state is in a single clk domain, with no combinational path from server_valid to readies.

Test Plan:
- Single client: n_clients=8. reqs=8'h04, payload 16'hABCD, server_req_ready=1.
  - Required: arbiter_req=1 with data ABCD one cycle later.
  - server_valid with 16'h1234 three cycles later → readies=8'h04, data_out=1234 for one cycle, outstanding back to 0.
- Round-robin fairness: reqs=8'hFF held, each client re-raising after its ready, server_req_ready=1, server answering 2 cycles after issue.
  - Required: grant order 0,1,...,7,0.
  - At most 4 outstanding.
  - No client granted twice while pending.
- Backpressure: server_req_ready=0 for 5 cycles with reqs=8'h03.
  - Required: arbiter_req and data stay stable.
  - Only one request is loaded, outstanding=1.
  - After ready rises, client 1 issues on the next cycle.
- FIFO full: 4 grants with no responses, then client 5 requests.
  - Required: no grant while outstanding=4.
  - One server_valid → readies hits the oldest client; client 5 is granted the following cycle.
- Simultaneous push/pop and underflow:
  - A grant and a server_valid in the same cycle → outstanding unchanged, correct tag routed.
  - server_valid with an empty FIFO → readies=0, resp_underflow=1 until reset.
- Reset mid-operation: assert reset with 3 outstanding.
  - Required: next cycle all outputs 0, outstanding=0, pointer 0.
  - A later stray server_valid sets resp_underflow.

Source files
------------

// File: rtl/pipelined_rr_arbiter.sv
// ============================================================================
// Module  : pipelined_rr_arbiter
// Brief   : Round-robin arbiter keeping several requests in flight to one
//           pipelined server; a tag FIFO routes in-order responses back.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module pipelined_rr_arbiter #(
  parameter int REQ_DATA_WIDTH    = 16,
  parameter int SERVER_DATA_WIDTH = 16,
  parameter int N_CLIENTS         = 8,
  parameter int MAX_OUTSTANDING   = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_CLIENTS*REQ_DATA_WIDTH-1:0]    req_data_flat,
  input  logic [N_CLIENTS-1:0]                   reqs,
  output logic [SERVER_DATA_WIDTH-1:0]           data_out,
  output logic [N_CLIENTS-1:0]                   readies,
  output logic [REQ_DATA_WIDTH-1:0]              arbiter_req_data,
  output logic                                   arbiter_req,
  input  logic                                   server_req_ready,
  input  logic [SERVER_DATA_WIDTH-1:0]           server_data,
  input  logic                                   server_valid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   resp_underflow
);

  localparam int c_tag_w = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int c_ptr_w = $clog2(MAX_OUTSTANDING);
  localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [N_CLIENTS-1:0] c_one = N_CLIENTS'(1);

  logic [c_tag_w-1:0]        r_ptr;
  logic [c_tag_w-1:0]        r_tags [MAX_OUTSTANDING];
  logic [c_ptr_w-1:0]        r_wr_ptr;
  logic [c_ptr_w-1:0]        r_rd_ptr;
  logic [c_cnt_w-1:0]        r_count;
  logic [N_CLIENTS-1:0]      r_pending;

  logic [N_CLIENTS-1:0]      w_eligible;
  logic                      w_found;
  logic [c_tag_w-1:0]        w_k;
  logic [c_tag_w-1:0]        w_next_ptr;
  logic                      w_grant;
  logic                      w_pop;
  logic [c_tag_w-1:0]        w_head;
  logic [N_CLIENTS-1:0]      w_grant_mask;
  logic [N_CLIENTS-1:0]      w_pop_mask;
  logic [REQ_DATA_WIDTH-1:0] w_sel_data;
  logic [c_cnt_w-1:0]        w_count_next;

  assign w_eligible = reqs & ~r_pending;
  assign outstanding = r_count;

  // First eligible client at or after the pointer, wrapping to 0.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_k     = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N_CLIENTS) idx = idx - N_CLIENTS;
      if (!w_found && w_eligible[idx]) begin
        w_found = 1'b1;
        w_k     = idx[c_tag_w-1:0];
      end
    end
  end

  assign w_next_ptr = (w_k == c_tag_w'(N_CLIENTS - 1)) ? '0 : w_k + 1'b1;
  assign w_sel_data = req_data_flat[w_k*REQ_DATA_WIDTH +: REQ_DATA_WIDTH];

  // The output register may reload in the same cycle it hands off to the server.
  assign w_grant = w_found
                && (r_count < c_cnt_w'(MAX_OUTSTANDING))
                && (!arbiter_req || server_req_ready);
  assign w_pop   = server_valid && (r_count != '0);
  assign w_head  = r_tags[r_rd_ptr];

  assign w_grant_mask = w_grant ? (c_one << w_k)    : '0;
  assign w_pop_mask   = w_pop   ? (c_one << w_head) : '0;

  always_comb begin
    w_count_next = r_count;
    case ({w_grant, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr            <= '0;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_pending        <= '0;
      arbiter_req      <= 1'b0;
      arbiter_req_data <= '0;
      data_out         <= '0;
      readies          <= '0;
      resp_underflow   <= 1'b0;
    end else begin
      if (w_grant) begin
        arbiter_req      <= 1'b1;
        arbiter_req_data <= w_sel_data;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
        r_ptr            <= w_next_ptr;
      end else if (server_req_ready) begin
        arbiter_req <= 1'b0;
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        data_out <= server_data;
      end
      readies <= w_pop_mask;

      // A client's pending bit drops on the edge ending its ready pulse.
      r_pending <= (r_pending & ~readies) | w_grant_mask;

      if (server_valid && (r_count == '0)) resp_underflow <= 1'b1;
      r_count <= w_count_next;
    end
  end

  // Tag storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_grant) r_tags[r_wr_ptr] <= w_k;
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_rr_arbiter.sv
// ============================================================================
// Module  : tb_pipelined_rr_arbiter
// Brief   : Directed self-checking bench for pipelined_rr_arbiter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_rr_arbiter;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int SW = 16;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*DW-1:0] req_data_flat;
  logic [N-1:0]    reqs;
  logic [SW-1:0]   data_out;
  logic [N-1:0]    readies;
  logic [DW-1:0]   arbiter_req_data;
  logic            arbiter_req;
  logic            server_req_ready;
  logic [SW-1:0]   server_data;
  logic            server_valid;
  logic [2:0]      outstanding;
  logic            resp_underflow;

  int tests = 0;
  int fails = 0;

  pipelined_rr_arbiter #(
    .REQ_DATA_WIDTH(DW), .SERVER_DATA_WIDTH(SW), .N_CLIENTS(N), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset), .req_data_flat(req_data_flat), .reqs(reqs),
    .data_out(data_out), .readies(readies), .arbiter_req_data(arbiter_req_data),
    .arbiter_req(arbiter_req), .server_req_ready(server_req_ready),
    .server_data(server_data), .server_valid(server_valid),
    .outstanding(outstanding), .resp_underflow(resp_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; reqs = '0; server_valid = 1'b0; server_req_ready = 1'b1;
    server_data = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic set_payloads();
    for (int i = 0; i < N; i++) req_data_flat[i*DW +: DW] = 16'(16'h1000 + i);
  endtask

  initial begin
    int issues, cyc, id, exp_ready_id;
    logic [7:0] mpend;
    int dueq[$];
    int idq[$];

    req_data_flat = '0;
    set_payloads();
    do_reset();

    // Reset state
    chk("rst_arbiter_req", arbiter_req, 0);
    chk("rst_arbiter_req_data", arbiter_req_data, 0);
    chk("rst_readies", readies, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_underflow", resp_underflow, 0);

    // Single client
    req_data_flat[2*DW +: DW] = 16'hABCD;
    reqs = 8'h04;
    step();
    chk("single_req", arbiter_req, 1);
    chk("single_data", arbiter_req_data, 16'hABCD);
    chk("single_outstanding", outstanding, 1);
    step();
    chk("single_req_drop", arbiter_req, 0);
    step();
    server_valid = 1'b1; server_data = 16'h1234;
    step();
    chk("single_readies", readies, 8'h04);
    chk("single_data_out", data_out, 16'h1234);
    chk("single_outstanding0", outstanding, 0);
    server_valid = 1'b0; reqs = '0;
    step();
    chk("single_readies_pulse", readies, 0);
    chk("single_no_regrant", arbiter_req, 0);

    // Round-robin fairness with a 2-cycle server
    do_reset();
    set_payloads();
    issues = 0; cyc = 0; exp_ready_id = -1; mpend = '0;
    reqs = 8'hFF;
    while (issues < 9 && cyc < 60) begin
      step(); cyc++;
      if (exp_ready_id >= 0) begin
        chk("rr_readies", readies, 32'(1) << exp_ready_id);
        chk("rr_data_out", data_out, 32'(16'h5000 + exp_ready_id));
        mpend[exp_ready_id[2:0]] = 1'b0;
      end else begin
        chk("rr_readies_idle", readies, 0);
      end
      exp_ready_id = -1;
      chk("rr_outstanding_le4", 32'(outstanding <= 3'd4), 1);
      if (arbiter_req) begin
        id = int'(arbiter_req_data) - 16'h1000;
        chk("rr_order", id, issues % 8);
        chk("rr_not_pending", mpend[id[2:0]], 0);
        mpend[id[2:0]] = 1'b1;
        issues++;
        dueq.push_back(cyc + 2);
        idq.push_back(id);
      end
      server_valid = 1'b0;
      if (dueq.size() > 0 && dueq[0] == cyc) begin
        server_valid = 1'b1;
        server_data  = 16'(16'h5000 + idq[0]);
        exp_ready_id = idq[0];
        void'(dueq.pop_front());
        void'(idq.pop_front());
      end
      reqs = 8'hFF & ~readies;
    end
    chk("rr_issue_count", issues, 9);

    // Backpressure
    do_reset();
    server_req_ready = 1'b0;
    reqs = 8'h03;
    step();
    chk("bp_req", arbiter_req, 1);
    chk("bp_data", arbiter_req_data, 16'h1000);
    chk("bp_outstanding", outstanding, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_req", arbiter_req, 1);
      chk("bp_hold_data", arbiter_req_data, 16'h1000);
      chk("bp_hold_outstanding", outstanding, 1);
    end
    server_req_ready = 1'b1;
    step();
    chk("bp_next_req", arbiter_req, 1);
    chk("bp_next_data", arbiter_req_data, 16'h1001);
    chk("bp_next_outstanding", outstanding, 2);
    step();
    chk("bp_drain_req", arbiter_req, 0);

    // FIFO full
    do_reset();
    reqs = 8'h0F;
    step(); step(); step(); step();
    chk("full_outstanding4", outstanding, 4);
    reqs = 8'h2F;
    step();
    chk("full_block_req", arbiter_req, 0);
    chk("full_block_outstanding", outstanding, 4);
    step();
    chk("full_block_req2", arbiter_req, 0);
    server_valid = 1'b1; server_data = 16'h0F0F;
    step();
    chk("full_pop_readies", readies, 8'h01);
    chk("full_pop_data_out", data_out, 16'h0F0F);
    chk("full_pop_outstanding", outstanding, 3);
    chk("full_pop_no_grant", arbiter_req, 0);
    server_valid = 1'b0; reqs = 8'h2E;
    step();
    chk("full_c5_req", arbiter_req, 1);
    chk("full_c5_data", arbiter_req_data, 16'h1005);
    chk("full_c5_outstanding", outstanding, 4);

    // Simultaneous push and pop
    server_valid = 1'b1; server_data = 16'h1111;
    step();
    chk("pp_pre_readies", readies, 8'h02);
    chk("pp_pre_outstanding", outstanding, 3);
    reqs = 8'h2D; server_data = 16'h2222;
    step();
    chk("pp_readies", readies, 8'h04);
    chk("pp_data_out", data_out, 16'h2222);
    chk("pp_outstanding", outstanding, 3);
    chk("pp_req", arbiter_req, 1);
    chk("pp_data", arbiter_req_data, 16'h1000);
    server_valid = 1'b0; reqs = '0;

    // Underflow
    do_reset();
    server_valid = 1'b1; server_data = 16'h9999;
    step();
    chk("uf_readies", readies, 0);
    chk("uf_flag", resp_underflow, 1);
    chk("uf_outstanding", outstanding, 0);
    server_valid = 1'b0;
    step();
    chk("uf_sticky", resp_underflow, 1);

    // Reset mid-operation
    reqs = 8'h07;
    step(); step(); step();
    chk("mid_outstanding3", outstanding, 3);
    reset = 1'b1;
    step();
    chk("mid_rst_req", arbiter_req, 0);
    chk("mid_rst_data", arbiter_req_data, 0);
    chk("mid_rst_readies", readies, 0);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_underflow", resp_underflow, 0);
    reset = 1'b0; reqs = '0; server_valid = 1'b1;
    step();
    chk("mid_stray_underflow", resp_underflow, 1);
    chk("mid_stray_readies", readies, 0);
    server_valid = 1'b0; reqs = 8'hFF;
    step();
    chk("mid_ptr0_req", arbiter_req, 1);
    chk("mid_ptr0_data", arbiter_req_data, 16'h1000);
    reqs = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
